upload_arbiter: RTL and testbench

- N-channel upload arbiter and framer for the USB upload path; it is the generalised successor of the single-source upload path in the command processor.
- Any number of handlers (UART, SPI, ADC capture, ...) request the upload path. The arbiter grants one at a time, round-robin.
- It collects the granted handler's bytes into a packet buffer, then emits a framed packet to the USB upload interface with valid/ready backpressure.

---
 rtl/upload_arbiter.sv | 137 +++++++++++++
 tb/tb_upload_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upload_arbiter.sv
// upload_arbiter: round-robin N-channel upload arbiter that buffers one packet and emits it as a framed byte stream
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   upload_req          per-channel request, held high for the length of a packet
//   upload_data         per-channel data byte, channel i in bits [8i+7:8i]
//   upload_source       per-channel source ID byte, same packing
//   upload_valid        per-channel byte strobe
//   upload_ready        per-channel accept, only the granted channel while collecting
//   usb_upload_data     framed output byte: HDR0 HDR1 SRC LENH LENL payload CSUM
//   usb_upload_valid    output byte valid
//   usb_upload_ready    sink accept
//   busy                high whenever the arbiter is not idle
//   grant_ch            current or last granted channel
module upload_arbiter #(
  parameter int NUM_CH = 4,
  parameter int MAX_PKT = 256,
  parameter logic [7:0] HDR0 = 8'hAA,
  parameter logic [7:0] HDR1 = 8'h44,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   upload_req,
  input  logic [NUM_CH*8-1:0] upload_data,
  input  logic [NUM_CH*8-1:0] upload_source,
  input  logic [NUM_CH-1:0]   upload_valid,
  output logic [NUM_CH-1:0]   upload_ready,
  output logic [7:0]          usb_upload_data,
  output logic                usb_upload_valid,
  input  logic                usb_upload_ready,
  output logic                busy,
  output logic [CW-1:0]       grant_ch
);
  localparam int AW = $clog2(MAX_PKT);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(MAX_PKT);
  typedef enum logic [3:0] {IDLE, COLLECT, H0, H1, SRC, LENH, LENL, DATA, CSUM} state_t;
  state_t state;
  logic [CW-1:0] ptr, pick, nxt_ptr;
  logic found, can_take, take, acc;
  logic [CNTW-1:0] count, cnt_nx, rd_addr;
  logic [7:0] src, csum, g_data, ram_q;
  logic [15:0] len;
  logic [7:0] mem [MAX_PKT];
  // first requesting channel at or after ptr; scanning downward lets the nearest one win
  always_comb begin
    found = 1'b0;
    pick = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (upload_req[(int'(ptr) + i) % NUM_CH]) begin
        found = 1'b1;
        pick = CW'((int'(ptr) + i) % NUM_CH);
      end
  end
  assign nxt_ptr = grant_ch == CW'(NUM_CH - 1) ? '0 : grant_ch + 1'b1;
  assign can_take = state == COLLECT && count < FULL;
  assign upload_ready = can_take ? NUM_CH'(1) << grant_ch : '0;
  assign g_data = upload_data[grant_ch*8 +: 8];
  assign take = can_take && upload_valid[grant_ch];
  assign cnt_nx = count + CNTW'(take);
  assign usb_upload_valid = !(state inside {IDLE, COLLECT});
  assign busy = state != IDLE;
  assign acc = usb_upload_valid && usb_upload_ready;
  assign len = 16'(count);
  // read address is a register, so the byte after the one on the output is always ready
  assign ram_q = mem[rd_addr[AW-1:0]];
  always_ff @(posedge clk)
    if (take) mem[count[AW-1:0]] <= g_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      grant_ch <= '0;
      src <= '0;
      count <= '0;
      csum <= '0;
      rd_addr <= '0;
      usb_upload_data <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant_ch <= pick;
          src <= upload_source[pick*8 +: 8];
          csum <= upload_source[pick*8 +: 8];
          count <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          count <= cnt_nx;
          if (take) csum <= csum + g_data;
          // a byte taken in the cycle req falls is still counted via cnt_nx
          if (!upload_req[grant_ch] || count == FULL) begin
            rd_addr <= '0;
            if (cnt_nx == '0) begin
              state <= IDLE;
              ptr <= nxt_ptr;
            end else begin
              state <= H0;
              usb_upload_data <= HDR0;
            end
          end
        end
        H0: if (acc) begin
          state <= H1;
          usb_upload_data <= HDR1;
        end
        H1: if (acc) begin
          state <= SRC;
          usb_upload_data <= src;
        end
        SRC: if (acc) begin
          state <= LENH;
          usb_upload_data <= len[15:8];
        end
        LENH: if (acc) begin
          state <= LENL;
          usb_upload_data <= len[7:0];
        end
        LENL: if (acc) begin
          state <= DATA;
          usb_upload_data <= ram_q;
          rd_addr <= rd_addr + 1'b1;
        end
        DATA: if (acc) begin
          state <= rd_addr == count ? CSUM : DATA;
          usb_upload_data <= rd_addr == count ? csum + len[15:8] + len[7:0] : ram_q;
          rd_addr <= rd_addr == count ? rd_addr : rd_addr + 1'b1;
        end
        CSUM: if (acc) begin
          state <= IDLE;
          ptr <= nxt_ptr;
          usb_upload_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter: randomized and directed checks of upload_arbiter against a frame-level reference model
module tb_upload_arbiter;
  localparam int NUM_CH = 4;
  localparam int MAX_PKT = 16;
  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h44;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0] upload_req = '0;
  logic [NUM_CH-1:0] upload_valid = '0;
  logic [NUM_CH-1:0] upload_ready;
  logic [NUM_CH*8-1:0] upload_data = '0;
  logic [NUM_CH*8-1:0] upload_source;
  logic [7:0] usb_upload_data;
  logic usb_upload_valid;
  logic usb_upload_ready = 1'b1;
  logic busy;
  logic [1:0] grant_ch;
  int nchk = 0;
  int nerr = 0;
  logic [7:0] src_id [NUM_CH] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] drv_bytes [NUM_CH][$];
  int drv_len [NUM_CH][$];
  logic [7:0] exp_bytes [NUM_CH][$];
  int exp_len [NUM_CH][$];
  bit act [NUM_CH];
  int rem [NUM_CH];
  int hold [NUM_CH];
  bit acc [NUM_CH];
  bit gaps = 0;
  int rdy_mode = 0;
  logic [7:0] frame [$];
  int fidx = 0;
  int cur = 0;
  int ptr_m = 0;
  int wait_ch = -1;
  bit arm = 1;
  bit inpkt [NUM_CH];
  int rem_m [NUM_CH];
  logic [NUM_CH-1:0] mask = '0;
  bit stall = 0;
  logic [7:0] stall_d = '0;

  upload_arbiter #(.NUM_CH(NUM_CH), .MAX_PKT(MAX_PKT), .HDR0(HDR0), .HDR1(HDR1)) dut (
    .clk(clk), .rst_n(rst_n),
    .upload_req(upload_req), .upload_data(upload_data), .upload_source(upload_source),
    .upload_valid(upload_valid), .upload_ready(upload_ready),
    .usb_upload_data(usb_upload_data), .usb_upload_valid(usb_upload_valid),
    .usb_upload_ready(usb_upload_ready), .busy(busy), .grant_ch(grant_ch)
  );

  always #5 clk = ~clk;
  for (genvar g = 0; g < NUM_CH; g++) assign upload_source[g*8 +: 8] = src_id[g];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // handler models: one packet at a time per channel, valid held until accepted
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) acc[c] = upload_valid[c] && upload_ready[c];
    @(posedge clk);
    #1;
    usb_upload_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~usb_upload_ready : 1'($urandom_range(0, 1));
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n) begin
        act[c] = 0;
        upload_req[c] = 1'b0;
        upload_valid[c] = 1'b0;
        drv_bytes[c].delete();
        drv_len[c].delete();
      end else if (act[c] && rem[c] == 0) begin
        hold[c]--;
        if (hold[c] == 0) begin
          act[c] = 0;
          upload_req[c] = 1'b0;
        end
      end else if (act[c]) begin
        if (acc[c]) begin
          void'(drv_bytes[c].pop_front());
          rem[c]--;
        end
        if (rem[c] == 0) begin
          act[c] = 0;
          upload_req[c] = 1'b0;
          upload_valid[c] = 1'b0;
        end else begin
          upload_data[c*8 +: 8] = drv_bytes[c][0];
          if (acc[c] || !upload_valid[c]) upload_valid[c] = !gaps || $urandom_range(0, 2) != 0;
        end
      end else if (!upload_req[c] && drv_len[c].size() > 0) begin
        act[c] = 1;
        rem[c] = drv_len[c].pop_front();
        hold[c] = 3;
        upload_req[c] = 1'b1;
        if (rem[c] > 0) begin
          upload_data[c*8 +: 8] = drv_bytes[c][0];
          upload_valid[c] = !gaps || $urandom_range(0, 2) != 0;
        end
      end
    end
  end

  // reference model: round-robin choice from the request vector seen while idle, frames built from packet chunks
  initial forever begin
    bit nxt;
    @(negedge clk);
    nxt = 0;
    if (!rst_n) begin
      frame.delete();
      fidx = 0;
      arm = 1;
      ptr_m = 0;
      wait_ch = -1;
      mask = '0;
      stall = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        exp_bytes[c].delete();
        exp_len[c].delete();
        inpkt[c] = 0;
        rem_m[c] = 0;
      end
    end else begin
      chk("ready_mask", upload_ready & ~(usb_upload_valid ? '0 : mask), 0);
      if (stall) begin
        chk("stall_valid", usb_upload_valid, 1);
        chk("stall_data", usb_upload_data, stall_d);
      end
      stall = usb_upload_valid && !usb_upload_ready;
      stall_d = usb_upload_data;
      if (usb_upload_valid && usb_upload_ready) begin
        chk("byte_expected", fidx < frame.size(), 1);
        if (fidx < frame.size()) begin
          chk($sformatf("frame_byte%0d", fidx), usb_upload_data, frame[fidx]);
          if (fidx == 0) chk("grant_ch", grant_ch, cur);
          fidx++;
          if (fidx == frame.size()) begin
            frame.delete();
            fidx = 0;
            mask = '0;
            nxt = 1;
          end
        end
      end
      if (wait_ch >= 0 && !upload_req[wait_ch]) begin
        wait_ch = -1;
        mask = '0;
        nxt = 1;
      end
      if (arm && upload_req != '0) begin
        for (int i = 0; i < NUM_CH; i++)
          if (upload_req[(ptr_m + i) % NUM_CH]) begin
            cur = (ptr_m + i) % NUM_CH;
            break;
          end
        arm = 0;
        ptr_m = (cur + 1) % NUM_CH;
        mask = '0;
        mask[cur] = 1'b1;
        if (!inpkt[cur]) begin
          chk("req_has_pkt", exp_len[cur].size() > 0, 1);
          rem_m[cur] = exp_len[cur].size() > 0 ? exp_len[cur].pop_front() : 0;
          inpkt[cur] = 1;
        end
        if (rem_m[cur] == 0) begin
          inpkt[cur] = 0;
          wait_ch = cur;
        end else begin
          int n;
          logic [7:0] sum, b;
          n = rem_m[cur] < MAX_PKT ? rem_m[cur] : MAX_PKT;
          rem_m[cur] -= n;
          if (rem_m[cur] == 0) inpkt[cur] = 0;
          sum = src_id[cur] + 8'(n >> 8) + 8'(n);
          frame = '{HDR0, HDR1, src_id[cur], 8'(n >> 8), 8'(n)};
          for (int i = 0; i < n; i++) begin
            b = exp_bytes[cur].pop_front();
            frame.push_back(b);
            sum += b;
          end
          frame.push_back(sum);
        end
      end
      if (nxt) arm = 1;
    end
  end

  task automatic add_pkt(input int c, input int len, input int step);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = step < 0 ? 8'($urandom) : 8'(step * (i + 1));
      drv_bytes[c].push_back(b);
      exp_bytes[c].push_back(b);
    end
    exp_len[c].push_back(len);
    drv_len[c].push_back(len);
  endtask

  function automatic bit idle_all();
    if (busy || frame.size() != 0 || wait_ch >= 0 || !arm) return 0;
    for (int c = 0; c < NUM_CH; c++)
      if (act[c] || inpkt[c] || drv_len[c].size() != 0 || exp_len[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_done(input string tag, input int maxc);
    int n;
    n = 0;
    while (n < maxc && !idle_all()) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_drain"}, n < maxc, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int run;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {usb_upload_data, usb_upload_valid, busy, grant_ch, upload_ready}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    // single channel, ready held high: 9 back-to-back output cycles
    add_pkt(1, 3, 8'h11);
    run = 0;
    for (int n = 0; n < 60 && !usb_upload_valid; n++) @(negedge clk);
    chk("single_busy", busy, 1);
    while (usb_upload_valid && run < 20) begin
      run++;
      @(negedge clk);
    end
    chk("single_run", run, 9);
    wait_done("single", 200);
    // simultaneous ch0/ch2, twice: pointer carries across rounds
    do_reset();
    add_pkt(0, 3, -1);
    add_pkt(2, 3, -1);
    wait_done("rr1", 300);
    add_pkt(0, 2, -1);
    add_pkt(2, 5, -1);
    wait_done("rr2", 300);
    // alternating sink backpressure
    do_reset();
    rdy_mode = 1;
    add_pkt(3, 4, -1);
    wait_done("bp", 300);
    rdy_mode = 0;
    // overflow: 20 bytes with req held split into 16 + 4
    do_reset();
    add_pkt(0, 20, -1);
    wait_done("ovf", 500);
    // empty request advances the pointer past ch1, so ch3 wins over ch1
    do_reset();
    add_pkt(1, 0, 0);
    wait_done("empty", 100);
    chk("empty_busy", busy, 0);
    add_pkt(1, 2, -1);
    add_pkt(3, 2, -1);
    wait_done("empty_rr", 300);
    // reset during the second payload byte
    do_reset();
    add_pkt(2, 6, -1);
    for (int n = 0; n < 300 && fidx != 6; n++) @(posedge clk);
    chk("mid_reach", fidx, 6);
    #3 rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {usb_upload_data, usb_upload_valid, busy, grant_ch, upload_ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    add_pkt(2, 5, -1);
    wait_done("after_reset", 300);
    // randomized traffic on all channels
    for (int r = 0; r < 2; r++) begin
      do_reset();
      gaps = 1;
      rdy_mode = r == 0 ? 2 : 0;
      for (int c = 0; c < NUM_CH; c++) src_id[c] = 8'($urandom);
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < 3; k++) add_pkt(c, $urandom_range(1, 40), -1);
      wait_done("random", 20000);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
